// File: rtl/bad_block_table_ctrl_pkg.sv
// bad_block_table_ctrl_pkg: FSM states and default parameters shared by the bad-block table and NAND command FSM
package bad_block_table_ctrl_pkg;
  localparam int BBT_ROW_W   = 24;
  localparam int BBT_BLK_LSB = 7;
  localparam int BBT_BLK_W   = 12;
  localparam int BBT_QDEPTH  = 4;
  localparam int BBT_SETTLE  = 2;
  localparam int BBT_MAX_BAD = 80;
  typedef enum logic [2:0] {IDLE, INIT, M_ADDR, M_CHK, M_WR, Q_RD, Q_CHK} bbt_state_e;
endpackage

// File: rtl/bad_block_table_ctrl_req_fifo.sv
// bbt_req_fifo: synchronous FIFO with full/empty flags; a pop frees its slot for a push in the same cycle
module bbt_req_fifo
  import bad_block_table_ctrl_pkg::*;
#(
  parameter int W     = BBT_BLK_W,
  parameter int DEPTH = BBT_QDEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         do_push, do_pop;
  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rp_q[AW-1:0]];
  assign wp_d    = wp_q + (AW+1)'(do_push);
  assign rp_d    = rp_q + (AW+1)'(do_pop);
  // pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // storage is unreset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/bad_block_table_ctrl.sv
// bad_block_table_ctrl: queues mark-bad requests, read-before-write into the bitmap RAM, queries, clear sweep, bad count
module bad_block_table_ctrl
  import bad_block_table_ctrl_pkg::*;
#(
  parameter int ROW_W   = BBT_ROW_W,
  parameter int BLK_LSB = BBT_BLK_LSB,
  parameter int BLK_W   = BBT_BLK_W,
  parameter int QDEPTH  = BBT_QDEPTH,
  parameter int SETTLE  = BBT_SETTLE,
  parameter int MAX_BAD = BBT_MAX_BAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mark_valid,
  output logic             mark_ready,
  input  logic [ROW_W-1:0] mark_row,
  input  logic             query_valid,
  output logic             query_ready,
  input  logic [BLK_W-1:0] query_blk,
  output logic             query_done,
  output logic             query_bad,
  input  logic             init_start,
  output logic [BLK_W-1:0] ram_addr,
  output logic             ram_we,
  output logic             ram_din,
  input  logic             ram_dout,
  output logic             end_bad_block_renew,
  output logic             en_bad_block_renew_transfer,
  output logic [BLK_W:0]   bad_count,
  output logic             bad_limit,
  output logic             busy
);
  localparam logic [BLK_W:0]   CNT_SAT     = {1'b1, {BLK_W{1'b0}}};
  localparam logic [BLK_W:0]   LIMIT       = (BLK_W+1)'(MAX_BAD);
  localparam logic [BLK_W-1:0] SETTLE_LAST = BLK_W'(SETTLE - 1);
  bbt_state_e       state_q, state_d;
  logic [BLK_W-1:0] cyc_q, cyc_d, mblk_q, qblk_q, mblk, fifo_dout;
  logic [BLK_W:0]   cnt_q, cnt_d;
  logic             qbad_q, end_q, limit_q, fifo_full, fifo_empty, pop, row_unused;
  bbt_req_fifo #(.W(BLK_W), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (mark_valid),
    .din_i   (mark_row[BLK_LSB +: BLK_W]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign row_unused  = ^mark_row;
  assign pop         = state_q == M_ADDR && cyc_q == '0;
  assign mblk        = pop ? fifo_dout : mblk_q;
  assign cyc_d       = state_d != state_q ? '0 : cyc_q + 1'b1;
  assign cnt_d       = state_q == IDLE && state_d == INIT ? '0 :
                       state_q == M_WR && cnt_q != CNT_SAT ? cnt_q + 1'b1 : cnt_q;
  assign mark_ready  = !fifo_full || pop;
  assign query_ready = state_q == IDLE && fifo_empty && !init_start;
  assign query_done  = state_q == Q_CHK;
  assign query_bad   = state_q == Q_CHK ? ram_dout : qbad_q;
  assign end_bad_block_renew         = end_q;
  assign en_bad_block_renew_transfer = state_q == M_WR;
  assign bad_count   = cnt_q;
  assign bad_limit   = limit_q;
  assign busy        = state_q != IDLE || !fifo_empty;
  // next state and RAM drive; cyc_q is the INIT address and the settle timer
  always_comb begin
    state_d  = state_q;
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = 1'b0;
    case (state_q)
      IDLE: state_d = init_start ? INIT : !fifo_empty ? M_ADDR : query_valid ? Q_RD : IDLE;
      INIT: begin
        state_d  = &cyc_q ? IDLE : INIT;
        ram_addr = cyc_q;
        ram_we   = 1'b1;
      end
      M_ADDR: begin
        state_d  = cyc_q == SETTLE_LAST ? M_CHK : M_ADDR;
        ram_addr = mblk;
      end
      M_CHK: begin
        state_d  = ram_dout ? IDLE : M_WR;
        ram_addr = mblk_q;
      end
      M_WR: begin
        state_d  = IDLE;
        ram_addr = mblk_q;
        ram_we   = 1'b1;
        ram_din  = 1'b1;
      end
      Q_RD: begin
        state_d  = cyc_q == SETTLE_LAST ? Q_CHK : Q_RD;
        ram_addr = qblk_q;
      end
      Q_CHK: begin
        state_d  = IDLE;
        ram_addr = qblk_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, latched block indices, completion pulse, count and registered limit compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      mblk_q  <= '0;
      qblk_q  <= '0;
      qbad_q  <= 1'b0;
      end_q   <= 1'b0;
      cnt_q   <= '0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      mblk_q  <= mblk;
      qblk_q  <= state_q == IDLE && state_d == Q_RD ? query_blk : qblk_q;
      qbad_q  <= state_q == Q_CHK ? ram_dout : qbad_q;
      end_q   <= (state_q == M_CHK && ram_dout) || state_q == M_WR;
      cnt_q   <= cnt_d;
      limit_q <= cnt_q >= LIMIT;
    end
  end
endmodule

// File: doc/bad_block_table_ctrl.md
Name: bad_block_table_ctrl

Overview:
- Parametrised bad-block table manager. Sits between the NAND command FSM (failed erase/program reports) and the single-port bad-block bitmap RAM, one bit per block.
- Queues mark-bad requests and does read-before-write, so duplicate marks are not double-counted.
- Serves "is block bad" queries, runs a table-clear sweep, keeps a bad-block count with a limit flag, and pulses the MCU-transfer strobe whenever a new bad block is committed.

Parameters:
- ROW_W, 24, width of the NAND row address.
- BLK_LSB, 7, bit position of the block index within the row address (pages per block = 2^BLK_LSB).
- BLK_W, 12, block index width; the table holds 2^BLK_W entries.
- QDEPTH, 4, mark-request FIFO depth (power of 2, >= 2).
- SETTLE, 2, cycles ram_addr is held before ram_dout is sampled (>= 1).
- MAX_BAD, 80, bad-block count at which bad_limit asserts.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mark_valid  in  1  mark-bad request.
- mark_ready  out  1  FIFO not full; transfer occurs when valid and ready are both high.
- mark_row  in  ROW_W  row address of the failed page.
- query_valid  in  1  lookup request.
- query_ready  out  1  high only in IDLE when no mark is pending and no init is starting.
- query_blk  in  BLK_W  block index to look up.
- query_done  out  1  one-cycle pulse; query_bad is valid in the same cycle.
- query_bad  out  1  1 = the queried block is bad; holds until the next query_done.
- init_start  in  1  pulse to clear the whole table.
- ram_addr  out  BLK_W  bitmap RAM address.
- ram_we  out  1  bitmap write enable.
- ram_din  out  1  bitmap write data.
- ram_dout  in  1  bitmap read data; 1-cycle read latency.
- end_bad_block_renew  out  1  one-cycle pulse per processed mark, new or duplicate.
- en_bad_block_renew_transfer  out  1  one-cycle pulse, coincident with ram_we, for new bad blocks only.
- bad_count  out  BLK_W+1  number of distinct bad blocks.
- bad_limit  out  1  asserted when bad_count >= MAX_BAD.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Reset values: all outputs 0, except mark_ready = 1 and query_ready = 1. FIFO empty, FSM in IDLE, bad_count = 0.
- Block index = mark_row[BLK_LSB+BLK_W-1 : BLK_LSB]. Stored in the FIFO as BLK_W bits.
- FIFO:
  - A push and a pop in the same cycle are both allowed, including when the FIFO is full (the pop frees a slot first, so mark_ready stays high).
  - Pushes are accepted in every FSM state, including INIT.
- Arbitration in IDLE, fixed priority: init_start > FIFO non-empty > query_valid. init_start outside IDLE is ignored.
- INIT:
  - ram_we = 1, ram_din = 0; ram_addr counts 0 .. 2^BLK_W-1, one entry per cycle.
  - Last address is written, then the FSM returns to IDLE.
  - bad_count clears to 0 on entry.
  - Duration is exactly 2^BLK_W cycles.
- M_ADDR: pop the FIFO head into a register, drive ram_addr, ram_we = 0; hold for SETTLE cycles.
- M_CHK: sample ram_dout.
  - 1 (duplicate): pulse end_bad_block_renew, go to IDLE. No write, count unchanged.
  - 0 (new block): go to M_WR.
- M_WR: one cycle.
  - ram_we = 1, ram_din = 1, en_bad_block_renew_transfer = 1.
  - bad_count increments, saturating at 2^BLK_W.
  - Next cycle: end_bad_block_renew pulse and return to IDLE.
- Mark latency, from pop to end_bad_block_renew: SETTLE+1 cycles for a duplicate, SETTLE+2 cycles for a new block.
- Q_RD: latch query_blk, drive ram_addr, hold for SETTLE cycles.
- Q_CHK: query_bad <= ram_dout, pulse query_done, return to IDLE.
- ram_addr and ram_din return to 0 in IDLE.
- bad_limit is a registered compare, updated the cycle after bad_count changes.
- Reset mid-operation: everything returns to reset values immediately. Queued marks are lost. No partial write continues, because ram_we is forced to 0 asynchronously.

Decomposition:
- Shared package: FSM state enum (IDLE, INIT, M_ADDR, M_CHK, M_WR, Q_RD, Q_CHK) and default parameter constants. The package is also imported by the NAND command FSM.
- Sub-module: bbt_req_fifo, a synchronous FIFO parametrised by width and depth, with full/empty flags and simultaneous push/pop support.

Test Plan:
- Reset, then mark_row = 0x000380 (block 7), RAM entry initially 0 -> ram_we pulse at ram_addr = 7 with ram_din = 1; en_bad_block_renew_transfer coincident; end_bad_block_renew 4 cycles after pop; bad_count = 1.
- Mark block 7 a second time -> no ram_we and no transfer pulse; end_bad_block_renew 3 cycles after pop; bad_count stays 1.
- Push 5 back-to-back marks with QDEPTH = 4 while the FSM is busy -> mark_ready drops after the 4th accepted request; all accepted marks are processed in order; no request is lost or duplicated.
- Query block 7 after it is marked -> query_done 3 cycles after acceptance with query_bad = 1; query block 8 -> query_bad = 0.
- init_start after 80 new marks (bad_limit = 1) -> 4096 consecutive write cycles with ram_din = 0; bad_count = 0; bad_limit = 0; a mark pushed during INIT is processed afterwards.
- Assert rst low in the M_WR cycle -> ram_we = 0 immediately; FIFO empty; busy = 0; mark_ready = 1.
